// File: rtl/ddr_rd_arbiter_pkg.sv
// ddr_rd_arbiter_pkg
// Shared definitions for the DDR read-master arbiter: FSM state encoding,
// burst geometry and grant-select encoding.
package ddr_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_LOAD = 2'd1,
        ST_NEXT = 2'd2
    } arb_state_e;

    // One burst = 16 beats x 64 bit.
    localparam int DEF_BYTES_PER_BURST = 128;

    // Burst counts are converted to byte offsets by shifting, so the burst
    // size must be a power of two.
    function automatic int burst_shift(input int bytes_per_burst);
        return $clog2(bytes_per_burst);
    endfunction

    localparam int BURST_SHIFT = burst_shift(DEF_BYTES_PER_BURST);

    localparam logic SEL_WEI = 1'b0;
    localparam logic SEL_FTM = 1'b1;

endpackage

// File: rtl/ddr_rd_arbiter_if.sv
// ddr_rd_arbiter_if
// Handshake to the single DDR AXI read master.
//   RSTART_REG  : start level, held until the master reports END
//   RADDR_REG   : chunk start byte address
//   RNBURST_REG : chunk burst count
//   RDONE_REG   : END level from the read master
// Modports: master = arbiter side, slave = read-master side.
interface ddr_rd_arbiter_if;
    logic        RSTART_REG;
    logic [31:0] RADDR_REG;
    logic [31:0] RNBURST_REG;
    logic        RDONE_REG;

    modport master (
        output RSTART_REG,
        output RADDR_REG,
        output RNBURST_REG,
        input  RDONE_REG
    );

    modport slave (
        input  RSTART_REG,
        input  RADDR_REG,
        input  RNBURST_REG,
        output RDONE_REG
    );
endinterface

// File: rtl/ddr_rd_arbiter_ctx.sv
// ddr_rd_ctx
// One requester context: accepts a request, tracks the next byte address
// and the remaining bursts, offers the next chunk size min(UNIT, rem) and
// pulses done when the request is exhausted.
// Ports:
//   clk, rstn                  clock / async active-low reset
//   req_valid/req_ready        request handshake (ready = context free)
//   req_addr, req_nburst       request start address and total bursts
//   chunk_end                  arbiter saw END for a chunk of this context
//   active, addr, cn           context state and next chunk size
//   done                       one-cycle pulse, request finished
module ddr_rd_ctx #(
    parameter int UNIT       = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NB_WIDTH   = 18,
    parameter int SHIFT      = 7
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [NB_WIDTH-1:0]   req_nburst,
    input  logic                  chunk_end,
    output logic                  active,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [NB_WIDTH-1:0]   cn,
    output logic                  done
);

    localparam logic [NB_WIDTH-1:0] UNIT_NB = NB_WIDTH'(UNIT);

    logic                  active_q, active_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NB_WIDTH-1:0]   rem_q, rem_d;
    logic                  fin_q, fin_d;
    logic                  done_q, done_d;
    logic [NB_WIDTH-1:0]   cn_w;
    logic                  accept;
    logic                  last;

    assign cn_w   = (rem_q > UNIT_NB) ? UNIT_NB : rem_q;
    assign last   = (rem_q == cn_w);
    assign accept = req_valid & ~active_q;

    // done is registered on the END edge so it is visible during the
    // arbiter's first NEXT cycle; the context itself is advanced at the
    // end of that cycle (fin_q), before the arbiter returns to ARB.
    always_comb begin
        active_d = active_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        fin_d    = chunk_end;
        done_d   = chunk_end & last;
        if (accept) begin
            addr_d   = req_addr;
            rem_d    = req_nburst;
            active_d = (req_nburst != '0);
            if (req_nburst == '0) begin
                done_d = 1'b1;
            end
        end
        if (fin_q) begin
            addr_d = addr_q + (ADDR_WIDTH'(cn_w) << SHIFT);
            rem_d  = rem_q - cn_w;
            if (rem_d == '0) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            active_q <= 1'b0;
            addr_q   <= '0;
            rem_q    <= '0;
            fin_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            fin_q    <= fin_d;
            done_q   <= done_d;
        end
    end

    assign req_ready = ~active_q;
    assign active    = active_q;
    assign addr      = addr_q;
    assign cn        = cn_w;
    assign done      = done_q;

endmodule

// File: rtl/ddr_rd_arbiter.sv
// ddr_rd_arbiter
// Shares the DDR read master between the weight loader (wei) and the
// feature-map loader (ftm). Requests are cut into unit-sized chunks and
// arbitration is redone after every chunk; a requester whose destination
// buffer is full is skipped. gnt_sel/gnt_valid steer returning beats.
// Ports:
//   clk, rstn                          clock / async active-low reset
//   wei_req_*, ftm_req_*               request handshakes
//   wb_full, fb_full                   destination buffer full
//   wei_done, ftm_done                 request-finished pulses
//   ddr                                read-master handshake (master modport)
//   gnt_valid, gnt_sel                 chunk in flight / owner (0 wei, 1 ftm)
//   busy                               any context active or FSM not idle
// Build option: DDR_ARB_WEI_PRIO_EN -- fixed priority to wei instead of
// round-robin when both requesters are eligible.
//
// state | meaning
// ARB   | pick an eligible requester, latch its chunk
// LOAD  | RSTART_REG high, address/count held, wait for RDONE_REG
// NEXT  | start dropped, context advanced, wait for RDONE_REG low
module ddr_rd_arbiter
    import ddr_rd_arbiter_pkg::*;
#(
    parameter int UNIT_BURSTS_WEI = 32,
    parameter int UNIT_BURSTS_FTM = 1024,
    parameter int BYTES_PER_BURST = ddr_rd_arbiter_pkg::DEF_BYTES_PER_BURST,
    parameter int ADDR_WIDTH      = 32,
    parameter int NB_WIDTH        = 18
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wei_req_valid,
    output logic                  wei_req_ready,
    input  logic [ADDR_WIDTH-1:0] wei_req_addr,
    input  logic [NB_WIDTH-1:0]   wei_req_nburst,
    input  logic                  ftm_req_valid,
    output logic                  ftm_req_ready,
    input  logic [ADDR_WIDTH-1:0] ftm_req_addr,
    input  logic [NB_WIDTH-1:0]   ftm_req_nburst,
    input  logic                  wb_full,
    input  logic                  fb_full,
    output logic                  wei_done,
    output logic                  ftm_done,
    ddr_rd_arbiter_if.master      ddr,
    output logic                  gnt_valid,
    output logic                  gnt_sel,
    output logic                  busy
);

    localparam int SHIFT = burst_shift(BYTES_PER_BURST);

    logic                  w_active, f_active;
    logic [ADDR_WIDTH-1:0] w_addr, f_addr;
    logic [NB_WIDTH-1:0]   w_cn, f_cn;
    logic                  elig_w, elig_f;
    logic                  pick_ftm;
    logic                  chunk_end;

    arb_state_e            state_q, state_d;
    logic                  sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] caddr_q, caddr_d;
    logic [NB_WIDTH-1:0]   cn_q, cn_d;
    logic                  rstart_q, rstart_d;
    logic                  gnt_valid_q, gnt_valid_d;

    assign chunk_end = (state_q == ST_LOAD) & ddr.RDONE_REG;

    ddr_rd_ctx #(
        .UNIT       (UNIT_BURSTS_WEI),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NB_WIDTH   (NB_WIDTH),
        .SHIFT      (SHIFT)
    ) u_ctx_wei (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (wei_req_valid),
        .req_ready  (wei_req_ready),
        .req_addr   (wei_req_addr),
        .req_nburst (wei_req_nburst),
        .chunk_end  (chunk_end & (sel_q == SEL_WEI)),
        .active     (w_active),
        .addr       (w_addr),
        .cn         (w_cn),
        .done       (wei_done)
    );

    ddr_rd_ctx #(
        .UNIT       (UNIT_BURSTS_FTM),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NB_WIDTH   (NB_WIDTH),
        .SHIFT      (SHIFT)
    ) u_ctx_ftm (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (ftm_req_valid),
        .req_ready  (ftm_req_ready),
        .req_addr   (ftm_req_addr),
        .req_nburst (ftm_req_nburst),
        .chunk_end  (chunk_end & (sel_q == SEL_FTM)),
        .active     (f_active),
        .addr       (f_addr),
        .cn         (f_cn),
        .done       (ftm_done)
    );

    // Buffer-full only matters at the arbitration point; a chunk already
    // in LOAD runs to completion.
    assign elig_w = w_active & ~wb_full;
    assign elig_f = f_active & ~fb_full;

`ifdef DDR_ARB_WEI_PRIO_EN
    assign pick_ftm = elig_f & ~elig_w;
`else
    // rr_q holds the last granted requester; on a tie the other one wins.
    // Reset value ftm makes wei win the first tie.
    logic rr_q, rr_d;

    assign rr_d     = chunk_end ? sel_q : rr_q;
    assign pick_ftm = elig_f & (~elig_w | (rr_q == SEL_WEI));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_q <= SEL_FTM;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        caddr_d     = caddr_q;
        cn_d        = cn_q;
        rstart_d    = rstart_q;
        gnt_valid_d = gnt_valid_q;
        case (state_q)
            ST_ARB: begin
                if (elig_w | elig_f) begin
                    sel_d       = pick_ftm ? SEL_FTM : SEL_WEI;
                    caddr_d     = pick_ftm ? f_addr : w_addr;
                    cn_d        = pick_ftm ? f_cn : w_cn;
                    rstart_d    = 1'b1;
                    gnt_valid_d = 1'b1;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ddr.RDONE_REG) begin
                    rstart_d    = 1'b0;
                    gnt_valid_d = 1'b0;
                    state_d     = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (!ddr.RDONE_REG) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                rstart_d    = 1'b0;
                gnt_valid_d = 1'b0;
                state_d     = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_ARB;
            sel_q       <= SEL_WEI;
            caddr_q     <= '0;
            cn_q        <= '0;
            rstart_q    <= 1'b0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            caddr_q     <= caddr_d;
            cn_q        <= cn_d;
            rstart_q    <= rstart_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign ddr.RSTART_REG  = rstart_q;
    assign ddr.RADDR_REG   = 32'(caddr_q);
    assign ddr.RNBURST_REG = 32'(cn_q);
    assign gnt_valid       = gnt_valid_q;
    assign gnt_sel         = sel_q;
    assign busy            = w_active | f_active | (state_q != ST_ARB);

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
module tb_ddr_rd_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wei_req_valid = 1'b0;
    logic        wei_req_ready;
    logic [31:0] wei_req_addr = '0;
    logic [17:0] wei_req_nburst = '0;
    logic        ftm_req_valid = 1'b0;
    logic        ftm_req_ready;
    logic [31:0] ftm_req_addr = '0;
    logic [17:0] ftm_req_nburst = '0;
    logic        wb_full = 1'b0;
    logic        fb_full = 1'b0;
    logic        wei_done, ftm_done;
    logic        gnt_valid, gnt_sel, busy;
    logic        stall = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ddr_rd_arbiter_if ddr_if ();

    ddr_rd_arbiter dut (
        .clk            (clk),
        .rstn           (rstn),
        .wei_req_valid  (wei_req_valid),
        .wei_req_ready  (wei_req_ready),
        .wei_req_addr   (wei_req_addr),
        .wei_req_nburst (wei_req_nburst),
        .ftm_req_valid  (ftm_req_valid),
        .ftm_req_ready  (ftm_req_ready),
        .ftm_req_addr   (ftm_req_addr),
        .ftm_req_nburst (ftm_req_nburst),
        .wb_full        (wb_full),
        .fb_full        (fb_full),
        .wei_done       (wei_done),
        .ftm_done       (ftm_done),
        .ddr            (ddr_if),
        .gnt_valid      (gnt_valid),
        .gnt_sel        (gnt_sel),
        .busy           (busy)
    );

    // Read-master model: END rises a few cycles after start, falls after
    // start is dropped. stall freezes it to hold a chunk in LOAD.
    int lat_cnt;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ddr_if.RDONE_REG <= 1'b0;
            lat_cnt          <= 0;
        end else if (ddr_if.RSTART_REG && !ddr_if.RDONE_REG && !stall) begin
            if (lat_cnt == 3) begin
                ddr_if.RDONE_REG <= 1'b1;
                lat_cnt          <= 0;
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else if (!ddr_if.RSTART_REG && ddr_if.RDONE_REG) begin
            ddr_if.RDONE_REG <= 1'b0;
        end
    end

    // Chunk and done logger, sampled on the falling edge.
    logic [31:0] log_addr[$];
    logic [31:0] log_nb[$];
    logic        log_sel[$];
    logic        rs_prev = 1'b0;
    int          wei_done_cnt = 0, ftm_done_cnt = 0;
    int          wei_done_at = -1, ftm_done_at = -1;

    always @(negedge clk) begin
        if (ddr_if.RSTART_REG && !rs_prev) begin
            log_addr.push_back(ddr_if.RADDR_REG);
            log_nb.push_back(ddr_if.RNBURST_REG);
            log_sel.push_back(gnt_sel);
        end
        rs_prev <= ddr_if.RSTART_REG;
        if (wei_done) begin
            wei_done_cnt <= wei_done_cnt + 1;
            wei_done_at  <= log_addr.size();
        end
        if (ftm_done) begin
            ftm_done_cnt <= ftm_done_cnt + 1;
            ftm_done_at  <= log_addr.size();
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_chunk(input string tag, input int idx, input logic sel,
                             input logic [31:0] addr, input logic [31:0] nb);
        chk({tag, ".cnt"}, 64'(log_addr.size() > idx), 64'd1);
        chk({tag, ".sel"}, 64'(log_sel[idx]), 64'(sel));
        chk({tag, ".addr"}, 64'(log_addr[idx]), 64'(addr));
        chk({tag, ".nb"}, 64'(log_nb[idx]), 64'(nb));
    endtask

    // Called at a falling edge; the request is accepted on the next rise.
    task automatic post(input logic w, input logic f,
                        input logic [31:0] wa, input logic [17:0] wn,
                        input logic [31:0] fa, input logic [17:0] fn);
        wei_req_valid  = w;
        wei_req_addr   = wa;
        wei_req_nburst = wn;
        ftm_req_valid  = f;
        ftm_req_addr   = fa;
        ftm_req_nburst = fn;
        @(posedge clk);
        #1;
        wei_req_valid = 1'b0;
        ftm_req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000 && busy !== 1'b0; i++) @(negedge clk);
        chk(tag, 64'(busy), 64'd0);
    endtask

    initial begin
        int b, wd0, fd0;

        // Reset state
        #12;
        chk("rst.rstart", 64'(ddr_if.RSTART_REG), 64'd0);
        chk("rst.raddr", 64'(ddr_if.RADDR_REG), 64'd0);
        chk("rst.rnburst", 64'(ddr_if.RNBURST_REG), 64'd0);
        chk("rst.gnt_valid", 64'(gnt_valid), 64'd0);
        chk("rst.gnt_sel", 64'(gnt_sel), 64'd0);
        chk("rst.wei_ready", 64'(wei_req_ready), 64'd1);
        chk("rst.ftm_ready", 64'(ftm_req_ready), 64'd1);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.wei_done", 64'(wei_done), 64'd0);
        chk("rst.ftm_done", 64'(ftm_done), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Contention: wei 64 bursts and ftm 2048 bursts posted together
        b = log_addr.size(); wd0 = wei_done_cnt; fd0 = ftm_done_cnt;
        post(1'b1, 1'b1, 32'h0, 18'd64, 32'h0010_0000, 18'd2048);
        @(negedge clk);
        chk("lat.t1_rstart", 64'(ddr_if.RSTART_REG), 64'd0);
        chk("lat.t1_ready", 64'({wei_req_ready, ftm_req_ready}), 64'd0);
        @(negedge clk);
        chk("lat.t2_rstart", 64'(ddr_if.RSTART_REG), 64'd1);
        chk("lat.t2_gnt_valid", 64'(gnt_valid), 64'd1);
        chk("lat.t2_gnt_sel", 64'(gnt_sel), 64'd0);
        chk("lat.t2_rnburst", 64'(ddr_if.RNBURST_REG), 64'd32);
        wait_idle("cont.idle");
`ifdef DDR_ARB_WEI_PRIO_EN
        chk_chunk("cont.c0", b + 0, 1'b0, 32'h0000_0000, 32'd32);
        chk_chunk("cont.c1", b + 1, 1'b0, 32'h0000_1000, 32'd32);
        chk_chunk("cont.c2", b + 2, 1'b1, 32'h0010_0000, 32'd1024);
        chk_chunk("cont.c3", b + 3, 1'b1, 32'h0012_0000, 32'd1024);
        chk("cont.wei_done_at", 64'(wei_done_at), 64'(b + 2));
`else
        chk_chunk("cont.c0", b + 0, 1'b0, 32'h0000_0000, 32'd32);
        chk_chunk("cont.c1", b + 1, 1'b1, 32'h0010_0000, 32'd1024);
        chk_chunk("cont.c2", b + 2, 1'b0, 32'h0000_1000, 32'd32);
        chk_chunk("cont.c3", b + 3, 1'b1, 32'h0012_0000, 32'd1024);
        chk("cont.wei_done_at", 64'(wei_done_at), 64'(b + 3));
`endif
        chk("cont.ftm_done_at", 64'(ftm_done_at), 64'(b + 4));
        chk("cont.nchunks", 64'(log_addr.size()), 64'(b + 4));
        chk("cont.wei_done_n", 64'(wei_done_cnt - wd0), 64'd1);
        chk("cont.ftm_done_n", 64'(ftm_done_cnt - fd0), 64'd1);

        // Wei only: 70 bursts from 0x1000 -> 32, 32, 6
        b = log_addr.size(); wd0 = wei_done_cnt; fd0 = ftm_done_cnt;
        post(1'b1, 1'b0, 32'h0000_1000, 18'd70, 32'h0, 18'd0);
        wait_idle("wei.idle");
        chk_chunk("wei.c0", b + 0, 1'b0, 32'h0000_1000, 32'd32);
        chk_chunk("wei.c1", b + 1, 1'b0, 32'h0000_2000, 32'd32);
        chk_chunk("wei.c2", b + 2, 1'b0, 32'h0000_3000, 32'd6);
        chk("wei.nchunks", 64'(log_addr.size()), 64'(b + 3));
        chk("wei.done_n", 64'(wei_done_cnt - wd0), 64'd1);
        chk("wei.done_at", 64'(wei_done_at), 64'(b + 3));
        chk("wei.ftm_done_n", 64'(ftm_done_cnt - fd0), 64'd0);
        chk("wei.ready", 64'(wei_req_ready), 64'd1);

        // ftm with zero bursts: done next cycle, no DDR access
        b = log_addr.size(); fd0 = ftm_done_cnt;
        post(1'b0, 1'b1, 32'h0, 18'd0, 32'h0000_2000, 18'd0);
        @(negedge clk);
        chk("zero.done", 64'(ftm_done), 64'd1);
        chk("zero.ready", 64'(ftm_req_ready), 64'd1);
        chk("zero.busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("zero.done_clr", 64'(ftm_done), 64'd0);
        repeat (5) @(negedge clk);
        chk("zero.rstart", 64'(ddr_if.RSTART_REG), 64'd0);
        chk("zero.nchunks", 64'(log_addr.size()), 64'(b));
        chk("zero.done_n", 64'(ftm_done_cnt - fd0), 64'd1);

        // Full gating: fb_full holds ftm off while wei runs
        fb_full = 1'b1;
        b = log_addr.size(); wd0 = wei_done_cnt; fd0 = ftm_done_cnt;
        post(1'b1, 1'b1, 32'h0000_8000, 18'd64, 32'h0004_0000, 18'd4);
        for (int i = 0; i < 500 && wei_done_cnt == wd0; i++) @(negedge clk);
        chk("full.wei_done_n", 64'(wei_done_cnt - wd0), 64'd1);
        repeat (10) @(negedge clk);
        chk("full.nchunks", 64'(log_addr.size()), 64'(b + 2));
        chk_chunk("full.c0", b + 0, 1'b0, 32'h0000_8000, 32'd32);
        chk_chunk("full.c1", b + 1, 1'b0, 32'h0000_9000, 32'd32);
        chk("full.ftm_ready", 64'(ftm_req_ready), 64'd0);
        chk("full.busy", 64'(busy), 64'd1);
        chk("full.rstart", 64'(ddr_if.RSTART_REG), 64'd0);
        fb_full = 1'b0;
        wait_idle("full.idle");
        chk_chunk("full.c2", b + 2, 1'b1, 32'h0004_0000, 32'd4);
        chk("full.ftm_done_n", 64'(ftm_done_cnt - fd0), 64'd1);

        // Reset while a chunk is in LOAD
        stall = 1'b1;
        post(1'b1, 1'b0, 32'h0000_5000, 18'd10, 32'h0, 18'd0);
        for (int i = 0; i < 20 && ddr_if.RSTART_REG !== 1'b1; i++) @(negedge clk);
        chk("mid.rstart_hi", 64'(ddr_if.RSTART_REG), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid.rstart_lo", 64'(ddr_if.RSTART_REG), 64'd0);
        chk("mid.gnt_valid", 64'(gnt_valid), 64'd0);
        chk("mid.ready", 64'({wei_req_ready, ftm_req_ready}), 64'd3);
        chk("mid.busy", 64'(busy), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        stall = 1'b0;
        @(negedge clk);
        b = log_addr.size(); wd0 = wei_done_cnt;
        post(1'b1, 1'b0, 32'h0000_6000, 18'd3, 32'h0, 18'd0);
        wait_idle("mid.idle");
        chk_chunk("mid.c0", b + 0, 1'b0, 32'h0000_6000, 32'd3);
        chk("mid.nchunks", 64'(log_addr.size()), 64'(b + 1));
        chk("mid.wei_done_n", 64'(wei_done_cnt - wd0), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ddr_rd_arbiter.md
Name: ddr_rd_arbiter

Overview:
- Shares the single DDR AXI read master (RSTART_REG/RADDR_REG/RNBURST_REG/RDONE_REG handshake) between two requesters: weight loader (wei) and feature-map loader (ftm).
- Splits each request into unit-sized chunks and re-arbitrates after every chunk.
- Skips any requester whose destination buffer is full.
- Drives gnt_sel/gnt_valid so the downstream write-enable demux routes returning AXIS beats to wb or fb.

Parameters:
UNIT_BURSTS_WEI, 32, max bursts per wei chunk (power of 2)
UNIT_BURSTS_FTM, 1024, max bursts per ftm chunk (power of 2)
BYTES_PER_BURST, 128, bytes per burst (16 x 64-bit)
ADDR_WIDTH, 32, DDR byte address width
NB_WIDTH, 18, request burst-count width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
wei_req_valid  in  1  weight request valid
wei_req_ready  out  1  weight context free
wei_req_addr  in  ADDR_WIDTH  weight start byte address
wei_req_nburst  in  NB_WIDTH  weight total bursts
ftm_req_valid  in  1  ftm request valid
ftm_req_ready  out  1  ftm context free
ftm_req_addr  in  ADDR_WIDTH  ftm start byte address
ftm_req_nburst  in  NB_WIDTH  ftm total bursts
wb_full  in  1  weight buffer full; blocks wei grant
fb_full  in  1  feature buffer full; blocks ftm grant
wei_done  out  1  one-cycle pulse: weight request finished
ftm_done  out  1  one-cycle pulse: ftm request finished
RSTART_REG  out  1  read master start (level)
RADDR_REG  out  32  chunk byte address
RNBURST_REG  out  32  chunk burst count
RDONE_REG  in  1  read master END (level)
gnt_valid  out  1  chunk in flight
gnt_sel  out  1  0 = wei, 1 = ftm
busy  out  1  any context active or FSM not in ARB

Behaviour:
- Reset (async, rstn=0): all outputs 0 except wei_req_ready=ftm_req_ready=1. State=ARB. Contexts inactive. RR pointer=ftm, so wei wins the first tie. Mid-operation reset drops RSTART_REG immediately.
- Per-requester context: active, addr, rem (NB_WIDTH).
- Request acceptance:
  - req_ready = ~active. Accept on valid & ready: active<=1, addr<=req_addr, rem<=req_nburst.
  - Accepting nburst=0: no DDR access. done pulses the cycle after accept; active stays 0.
- Eligibility: elig_w = w.active & ~wb_full; elig_f = f.active & ~fb_full.
- FSM states:
  - ARB:
    - Neither eligible: stay.
    - One eligible: grant it.
    - Both eligible: grant the one not granted last.
    - On grant, latch sel, caddr=ctx.addr, cn=min(UNIT, ctx.rem); go to LOAD.
  - LOAD:
    - RSTART_REG=1; RADDR_REG=caddr; RNBURST_REG=cn zero-extended; gnt_valid=1; gnt_sel=sel.
    - All held stable until RDONE_REG=1, then go to NEXT.
  - NEXT:
    - RSTART_REG=0; gnt_valid=0.
    - Update granted ctx: addr += cn*BYTES_PER_BURST (modulo 2^ADDR_WIDTH); rem -= cn.
    - If the new rem is 0: done pulse this cycle, active<=0.
    - Update RR pointer = sel.
    - Wait for RDONE_REG=0, then go to ARB.
- Latency: accept at cycle T → ARB sees active at T+1 → RSTART_REG high at T+2 (no contention).
- Full is sampled only in ARB. A full asserted during LOAD does not abort the chunk.
- A context whose done fires may accept a new request from the next cycle on (ready rises with active=0).
- Simultaneous accept on both requesters is legal; contexts are independent.
- rem never underflows: cn ≤ rem by construction.

Optional Feature:
DDR_ARB_WEI_PRIO_EN
- Defined: fixed priority; wei always wins when both are eligible. RR pointer is unused.
- Undefined: round-robin as above.

Decomposition:
- Shared package: state encoding (ARB/LOAD/NEXT); BYTES_PER_BURST; log2 shift constant; SEL_WEI=0 / SEL_FTM=1 constants.
- Sub-module ddr_rd_ctx, instantiated twice: holds active/addr/rem, ready/done, and chunk-size min computation, parameterised by UNIT.

Test Plan:
- Wei only: addr=0x1000, nburst=70, UNIT_WEI=32 → three chunks (0x1000,32), (0x2000,32), (0x3000,6); one wei_done pulse after the third RDONE; gnt_sel=0 throughout.
- Contention, RR build: wei nburst=64 and ftm nburst=2048 posted together → grant order wei(32), ftm(1024), wei(32), ftm(1024); wei_done after the 3rd chunk, ftm_done after the 4th.
- Full gating: fb_full=1 with both active → only wei chunks issued. Drop fb_full → next ARB grants ftm.
- nburst=0 on ftm → ftm_done pulses the cycle after accept; RSTART_REG stays 0.
- Reset mid-LOAD: rstn low while RSTART_REG=1 → RSTART_REG=0 asynchronously, both req_ready=1, busy=0; fresh request then restarts at its own address.
- DDR_ARB_WEI_PRIO_EN defined with both contexts long-active → every grant goes to wei until wei_done, then ftm.
